// File: rtl/cache_refill_ctrl_if.sv
// AXI read/write channel bundle between the cache refill controller and the memory fabric.
// The master side is the refill controller and the slave side is the memory or interconnect.
interface cache_refill_ctrl_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;
  logic        bvalid;
  logic        bready;

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
    output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    input  arready, rvalid, rdata, rlast, awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
    input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
    output arready, rvalid, rdata, rlast, awready, wready, bvalid
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: optional dirty-victim write-back burst, then line refill (or single uncached read).
// Handshake strobes decode from registered state and are forced low while rst is high.
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      miss,
  input  logic                      cached,
  input  logic                      write_back,
  input  logic [31:0]               raddr,
  input  logic [31:0]               waddr,
  input  logic [31:0]               wb_rdata,
  output logic [2:0]                wb_idx,
  cache_refill_ctrl_if.master       axi,
  output logic                      refill_we,
  output logic [2:0]                refill_idx,
  output logic [31:0]               refill_wdata,
  output logic                      refresh,
  output logic [31:0]               uc_rdata,
  output logic                      stallreq,
  output logic                      done
);

  typedef enum logic [2:0] {
    IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, FILL_DONE
  } state_t;

  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);
  localparam logic [7:0] BURST_LEN = 8'(LINE_WORDS - 1);

  state_t      state;
  logic [31:0] raddr_q;
  logic [31:0] waddr_q;
  logic        cached_q;
  logic [2:0]  beat;
  logic        wb_vld;   // victim word for the current wb_idx has arrived
  logic        rd_full;  // every line word written; later beats are dropped
  logic        live;

  assign live = ~rst;

  // Write-back channel
  assign axi.awvalid = live && (state == WB_AW);
  assign axi.awaddr  = waddr_q;
  assign axi.awlen   = BURST_LEN;
  assign axi.wvalid  = live && (state == WB_W) && wb_vld;
  assign axi.wdata   = wb_rdata;
  assign axi.wlast   = axi.wvalid && (beat == LAST_BEAT);
  assign axi.bready  = live && (state == WB_B);
  assign wb_idx      = beat;

  // Refill channel
  assign axi.arvalid = live && (state == RD_AR);
  assign axi.araddr  = raddr_q;
  assign axi.arlen   = cached_q ? BURST_LEN : 8'd0;
  assign axi.arsize  = 3'd2;
  assign axi.rready  = live && (state == RD_R);

  assign refill_we    = axi.rready && axi.rvalid && cached_q && !rd_full;
  assign refill_idx   = beat;
  assign refill_wdata = axi.rdata;

  assign done     = live && (state == FILL_DONE);
  assign refresh  = done && cached_q;
  assign stallreq = (state != IDLE) || miss;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      raddr_q  <= '0;
      waddr_q  <= '0;
      cached_q <= 1'b0;
      beat     <= '0;
      wb_vld   <= 1'b0;
      rd_full  <= 1'b0;
      uc_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            raddr_q  <= raddr;
            waddr_q  <= waddr;
            cached_q <= cached;
            beat     <= '0;
            wb_vld   <= 1'b0;
            rd_full  <= 1'b0;
            state    <= (cached && write_back) ? WB_AW : RD_AR;
          end
        end
        WB_AW: begin
          if (axi.awready) begin
            beat   <= '0;
            wb_vld <= 1'b0;
            state  <= WB_W;
          end
        end
        WB_W: begin
          // A new index is presented after each accepted beat; its data lands one cycle later.
          if (axi.wvalid && axi.wready) begin
            wb_vld <= 1'b0;
            if (beat == LAST_BEAT) state <= WB_B;
            else                   beat  <= beat + 3'd1;
          end else begin
            wb_vld <= 1'b1;
          end
        end
        WB_B: begin
          if (axi.bvalid) state <= RD_AR;
        end
        RD_AR: begin
          if (axi.arready) begin
            beat    <= '0;
            rd_full <= 1'b0;
            state   <= RD_R;
          end
        end
        RD_R: begin
          if (axi.rvalid) begin
            if (!cached_q) begin
              uc_rdata <= axi.rdata;
            end else if (!rd_full) begin
              if (beat == LAST_BEAT) rd_full <= 1'b1;
              else                   beat    <= beat + 3'd1;
            end
            if (axi.rlast) state <= FILL_DONE;
          end
        end
        FILL_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: the bench plays the AXI slave and the victim data array.
// Inputs change #1 after the rising edge; a negedge monitor records strobes.
module tb_cache_refill_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        miss, cached, write_back;
  logic [31:0] raddr, waddr, wb_rdata;
  logic [2:0]  wb_idx, refill_idx;
  logic        refill_we, refresh, stallreq, done;
  logic [31:0] refill_wdata, uc_rdata;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl #(.LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .miss(miss), .cached(cached), .write_back(write_back),
    .raddr(raddr), .waddr(waddr), .wb_rdata(wb_rdata), .wb_idx(wb_idx), .axi(bus),
    .refill_we(refill_we), .refill_idx(refill_idx), .refill_wdata(refill_wdata),
    .refresh(refresh), .uc_rdata(uc_rdata), .stallreq(stallreq), .done(done)
  );

  always #5 clk = ~clk;

  // Victim data array model: word i of the dirty line is A000_0000 + i, one cycle read latency.
  always @(posedge clk) wb_rdata <= 32'hA000_0000 | {29'd0, wb_idx};

  int          tests = 0;
  int          fails = 0;
  int          we_cnt, refresh_cnt, done_cnt, w_cnt, rst_strobe_cnt;
  logic [2:0]  we_idx  [16];
  logic [31:0] we_data [16];
  logic [31:0] w_data  [16];
  logic [15:0] wlast_mask;

  always @(negedge clk) begin
    if (refill_we) begin
      if (we_cnt < 16) begin
        we_idx[we_cnt]  = refill_idx;
        we_data[we_cnt] = refill_wdata;
      end
      we_cnt++;
    end
    if (refresh) refresh_cnt++;
    if (done)    done_cnt++;
    if (bus.wvalid && bus.wready) begin
      if (w_cnt < 16) begin
        w_data[w_cnt] = bus.wdata;
        if (bus.wlast) wlast_mask[w_cnt] = 1'b1;
      end
      w_cnt++;
    end
    if (rst && (bus.arvalid || bus.rready || bus.awvalid || bus.wvalid || bus.wlast ||
                bus.bready || refill_we || refresh || done))
      rst_strobe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    we_cnt = 0; refresh_cnt = 0; done_cnt = 0; w_cnt = 0; wlast_mask = '0;
  endtask

  // Present a miss for one edge, then scramble the request inputs to prove they were captured.
  task automatic start_miss(input logic [31:0] r, input logic [31:0] w, input logic c,
                            input logic wbk, input logic keep);
    clear_mon();
    miss = 1'b1; raddr = r; waddr = w; cached = c; write_back = wbk;
    #1;
    check("stall_on_miss", 32'(stallreq), 32'd1);
    cycle();
    miss = keep; raddr = ~r; waddr = ~w; cached = ~c; write_back = ~wbk;
  endtask

  task automatic rd_slave(input logic [31:0] exp_addr, input logic [7:0] exp_len,
                          input int ar_delay, input int gap, input int beats,
                          input logic [31:0] base, input int drop_beat, input int rst_beat);
    int   found;
    logic stable;
    found = 0;
    for (int t = 0; t < 100; t++) begin
      if (bus.arvalid) begin found = 1; break; end
      cycle();
    end
    check("ar_seen", 32'(found), 32'd1);
    check("araddr", bus.araddr, exp_addr);
    check("arlen", 32'(bus.arlen), 32'(exp_len));
    check("arsize", 32'(bus.arsize), 32'd2);
    stable = 1'b1;
    for (int t = 0; t < ar_delay; t++) begin
      cycle();
      if (!bus.arvalid || bus.araddr !== exp_addr) stable = 1'b0;
    end
    check("ar_stable", 32'(stable), 32'd1);
    bus.arready = 1'b1;
    cycle();
    bus.arready = 1'b0;
    check("rready", 32'(bus.rready), 32'd1);
    for (int i = 0; i < beats; i++) begin
      if (gap != 0) begin
        bus.rvalid = 1'b0;
        cycle();
      end
      if (i == drop_beat) miss = 1'b0;
      bus.rvalid = 1'b1;
      bus.rdata  = base + 32'(i);
      bus.rlast  = (i == beats - 1);
      if (i == rst_beat) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        return;
      end
      cycle();
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
  endtask

  // Called in the cycle right after the final beat is accepted.
  task automatic finish_check(input logic c);
    check("done_pulse", 32'(done), 32'd1);
    check("refresh_pulse", 32'(refresh), 32'(c));
    cycle();
    check("done_cleared", 32'(done), 32'd0);
    check("stall_released", 32'(stallreq), 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("refresh_count", 32'(refresh_cnt), 32'(c));
  endtask

  task automatic check_refill(input logic [31:0] base);
    check("refill_writes", 32'(we_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("refill_idx", 32'(we_idx[i]), 32'(i));
      check("refill_wdata", we_data[i], base + 32'(i));
    end
  endtask

  initial begin
    int found;
    rst = 1'b1; miss = 1'b0; cached = 1'b0; write_back = 1'b0; raddr = '0; waddr = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    rst_strobe_cnt = 0;
    clear_mon();
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("reset_strobes", {23'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                            bus.wlast, bus.bready, refill_we, refresh, done}, 32'd0);
    check("reset_stall", 32'(stallreq), 32'd0);
    check("reset_uc_rdata", uc_rdata, 32'd0);

    // Clean cached miss
    start_miss(32'h1FC0_0020, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_slave(32'h1FC0_0020, 8'd7, 0, 0, 8, 32'd0, -1, -1);
    finish_check(1'b1);
    check_refill(32'd0);

    // Uncached single read at an unaligned address
    start_miss(32'hBFAF_F004, 32'h0, 1'b0, 1'b0, 1'b0);
    rd_slave(32'hBFAF_F004, 8'd0, 0, 0, 1, 32'hDEAD_BEEF, -1, -1);
    finish_check(1'b0);
    check("uc_no_refill", 32'(we_cnt), 32'd0);
    check("uc_rdata", uc_rdata, 32'hDEAD_BEEF);

    // Dirty victim: write-back burst, B response, then refill
    start_miss(32'h0000_2000, 32'h0000_1000, 1'b1, 1'b1, 1'b0);
    found = 0;
    for (int t = 0; t < 100; t++) begin
      if (bus.awvalid) begin found = 1; break; end
      cycle();
    end
    check("aw_seen", 32'(found), 32'd1);
    check("awaddr", bus.awaddr, 32'h0000_1000);
    check("awlen", 32'(bus.awlen), 32'd7);
    check("no_ar_before_wb", 32'(bus.arvalid), 32'd0);
    bus.awready = 1'b1;
    cycle();
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    found = 0;
    for (int t = 0; t < 200; t++) begin
      if (bus.bready) begin found = 1; break; end
      cycle();
    end
    bus.wready = 1'b0;
    check("b_seen", 32'(found), 32'd1);
    check("w_beats", 32'(w_cnt), 32'd8);
    for (int i = 0; i < 8; i++) check("w_data", w_data[i], 32'hA000_0000 + 32'(i));
    check("wlast_pos", 32'(wlast_mask), 32'h0000_0080);
    repeat (2) cycle();
    check("bready_held", 32'(bus.bready), 32'd1);
    check("no_ar_before_b", 32'(bus.arvalid), 32'd0);
    bus.bvalid = 1'b1;
    cycle();
    bus.bvalid = 1'b0;
    rd_slave(32'h0000_2000, 8'd7, 0, 0, 8, 32'h5000, -1, -1);
    finish_check(1'b1);
    check_refill(32'h5000);

    // Slow arready and gapped read data
    start_miss(32'h0040_0040, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_slave(32'h0040_0040, 8'd7, 5, 1, 8, 32'h100, -1, -1);
    finish_check(1'b1);
    check_refill(32'h100);

    // Reset on beat 3 abandons the burst; a fresh miss then runs a complete one
    start_miss(32'h0080_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_slave(32'h0080_0000, 8'd7, 0, 0, 8, 32'h200, -1, 3);
    check("abort_idle_stall", 32'(stallreq), 32'd0);
    check("abort_strobes", {29'd0, bus.arvalid, bus.rready, done}, 32'd0);
    repeat (3) cycle();
    check("abort_writes", 32'(we_cnt), 32'd3);
    check("abort_refresh", 32'(refresh_cnt + done_cnt), 32'd0);
    check("rst_strobes", 32'(rst_strobe_cnt), 32'd0);
    start_miss(32'h0080_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_slave(32'h0080_0000, 8'd7, 0, 0, 8, 32'h200, -1, -1);
    finish_check(1'b1);
    check_refill(32'h200);

    // miss stays high into RD_R and drops mid-burst
    start_miss(32'h00C0_0000, 32'h0, 1'b1, 1'b0, 1'b1);
    rd_slave(32'h00C0_0000, 8'd7, 0, 0, 8, 32'h400, 4, -1);
    finish_check(1'b1);
    check_refill(32'h400);

    // A ninth beat before rlast must not be written
    start_miss(32'h0100_0000, 32'h0, 1'b1, 1'b0, 1'b0);
    rd_slave(32'h0100_0000, 8'd7, 0, 0, 9, 32'h300, -1, -1);
    finish_check(1'b1);
    check_refill(32'h300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per cache line (32-byte line, 5-bit offset).
REQ-002 SHALL have clk input 1: clock, all logic on rising edge.
REQ-003 SHALL have rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have miss, cached, write_back inputs, 1 bit each: tag-lookup miss, access cacheable, victim line dirty.
REQ-005 SHALL have raddr and waddr inputs, 32 bits each: line-aligned refill address (full address when uncached) and victim line address.
REQ-006 SHALL have wb_rdata input 32: victim word from the data array, valid the cycle after wb_idx is presented.
REQ-007 SHALL have wb_idx output 3: victim word index.
REQ-008 SHALL have AXI read outputs arvalid 1, araddr 32, arlen 8, arsize 3, rready 1, and inputs arready 1, rvalid 1, rdata 32, rlast 1.
REQ-009 SHALL have AXI write outputs awvalid 1, awaddr 32, awlen 8, wvalid 1, wdata 32, wlast 1, bready 1, and inputs awready 1, wready 1, bvalid 1.
REQ-010 SHALL have data-array outputs refill_we 1, refill_idx 3, refill_wdata 32; refresh 1 (tag write strobe); uc_rdata 32; stallreq 1; done 1.

Function
REQ-011 SHALL implement states IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, FILL_DONE.
REQ-012 SHALL, in IDLE with miss=1, capture raddr/waddr/cached/write_back and go to WB_AW if cached&write_back, else RD_AR.
REQ-013 SHALL, in WB_AW, hold awvalid=1, awaddr=captured waddr, awlen=LINE_WORDS-1, until awready, then go to WB_W.
REQ-014 SHALL, in WB_W, drive wb_idx = beat counter, wdata=wb_rdata, wvalid=1 only when the fetched word is valid, advance the counter on wvalid&wready, assert wlast on beat LINE_WORDS-1, then go to WB_B.
REQ-015 SHALL, in WB_B, hold bready=1 and go to RD_AR on bvalid.
REQ-016 SHALL, in RD_AR, hold arvalid=1, araddr=captured raddr, arsize=2; arlen=LINE_WORDS-1 if cached, else 0; advance to RD_R on arready.
REQ-017 SHALL, in RD_R, hold rready=1; each rvalid beat when cached drives refill_we=1, refill_idx=beat count, refill_wdata=rdata in the same cycle; uncached beat latches rdata into uc_rdata.
REQ-018 SHALL leave RD_R to FILL_DONE on rvalid&rlast; SHALL NOT count beats beyond LINE_WORDS-1 (counter stops, no write).
REQ-019 SHALL, in FILL_DONE, assert done for exactly one cycle, assert refresh for that cycle only if cached, then return to IDLE.
REQ-020 SHALL keep arvalid/awvalid asserted, address stable, until accepted (no withdrawal).
REQ-021 SHALL assert stallreq = miss in IDLE, or any state other than IDLE (combinational); deassert in IDLE with miss=0.
REQ-022 SHALL ignore miss changes outside IDLE; captured values govern the transaction.
REQ-023 SHALL, for beat counters, use 3 bits, clear on state entry, no wrap within a burst.

Reset
REQ-024 SHALL, on rst, enter IDLE and clear counters, captured registers, uc_rdata.
REQ-025 SHALL hold every valid/ready/strobe output (arvalid, rready, awvalid, wvalid, wlast, bready, refill_we, refresh, done) at 0 during and after reset until a new miss.
REQ-026 SHALL abandon an in-flight burst on rst mid-operation with no refresh or refill_we issued after rst.

Verification
REQ-027 Clean cached miss, raddr=0x1FC0_0020, arready=1, 8 rvalid beats rdata=0..7 -> araddr=0x1FC0_0020, arlen=7, refill_we on 8 beats idx 0..7, refresh+done one cycle, stallreq low next cycle.
REQ-028 Uncached miss raddr=0xBFAF_F004, rdata=0xDEAD_BEEF -> arlen=0, araddr unaligned 0xBFAF_F004, no refill_we/refresh, uc_rdata=0xDEAD_BEEF, done pulse.
REQ-029 Dirty cached miss waddr=0x0000_1000 -> AW awlen=7, 8 W beats with wlast on 8th, wait bvalid, then AR, refill, refresh.
REQ-030 arready delayed 5 cycles, rvalid gaps every other cycle -> arvalid/araddr stable, refill_idx increments only on rvalid, total 8 writes.
REQ-031 rst asserted on beat 3 of RD_R -> next cycle IDLE, all strobes 0, no refresh; subsequent miss runs a full fresh burst.
REQ-032 miss deasserted while in RD_R -> transaction completes unchanged, done pulses once.
